// File: rtl/uart_tx_sequencer_pkg.sv
// Shared types and constants for the UART transmit sequencer.
// Encodings are fixed so the status word layout stays stable for firmware.
package uart_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    SEND_CR = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  localparam int STATUS_BUSY_BIT = 9;
  localparam int STATUS_OVF_BIT  = 10;

  // Level is carried in the low five bits; wider levels are truncated.
  function automatic logic [31:0] pack_status(input logic ovf, input logic bsy,
                                              input logic [31:0] lvl);
    logic [31:0] s;
    s = '0;
    s[4:0] = lvl[4:0];
    s[STATUS_BUSY_BIT] = bsy;
    s[STATUS_OVF_BIT] = ovf;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// Byte handshake between the sequencer (master) and the UART emitter (slave).
interface uart_tx_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_sequencer_fifo.sv
// Synchronous FIFO with one extra pointer bit to separate full from empty.
// The head is read from registered storage, so a fresh push is visible one cycle later.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LVL_W-1:0] wr_ptr;
  logic [LVL_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + LVL_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[LVL_W-1] != rd_ptr[LVL_W-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_sequencer.sv
// Queues CPU-written bytes and hands them one at a time to the UART emitter.
// Optional macro UART_TX_CRLF_EN inserts a CR ahead of every LF.
module uart_tx_sequencer
  import uart_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   clr_ovf,
  uart_tx_sequencer_if.master    tx,
  output logic                   busy,
  output logic                   full,
  output logic                   overflow,
  output logic [LVL_W-1:0]       level,
  output logic [31:0]            status
);

  state_t     state, state_n;
  logic [7:0] tx_data_q, tx_data_n;
  logic       tx_valid_q, tx_valid_n;
  logic       pop;
  logic       empty;
  logic [7:0] head;
`ifdef UART_TX_CRLF_EN
  logic       cr_sent, cr_sent_n;
`endif

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
`ifdef UART_TX_CRLF_EN
      cr_sent    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      tx_data_q  <= tx_data_n;
      tx_valid_q <= tx_valid_n;
`ifdef UART_TX_CRLF_EN
      cr_sent    <= cr_sent_n;
`endif
    end
  end

  // Bytes are only loaded in IDLE, so tx_data never moves under a pending valid.
  always_comb begin
    state_n    = state;
    tx_data_n  = tx_data_q;
    tx_valid_n = tx_valid_q;
    pop        = 1'b0;
`ifdef UART_TX_CRLF_EN
    cr_sent_n  = cr_sent;
`endif
    case (state)
      IDLE: begin
        if (!empty) begin
`ifdef UART_TX_CRLF_EN
          if (head == ASCII_LF && !cr_sent) begin
            tx_data_n  = ASCII_CR;
            tx_valid_n = 1'b1;
            cr_sent_n  = 1'b1;
            state_n    = SEND_CR;
          end else begin
            tx_data_n  = head;
            tx_valid_n = 1'b1;
            pop        = 1'b1;
            cr_sent_n  = 1'b0;
            state_n    = SEND;
          end
`else
          tx_data_n  = head;
          tx_valid_n = 1'b1;
          pop        = 1'b1;
          state_n    = SEND;
`endif
        end
      end
      SEND, SEND_CR: begin
        if (tx_valid_q && tx.tx_ready) begin
          tx_valid_n = 1'b0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A dropped push outranks a clear in the same cycle so no loss goes unreported.
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (push && full) overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = !empty || tx_valid_q;
  assign status      = pack_status(overflow, busy, 32'(level));

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed self-checking bench for uart_tx_sequencer (DEPTH=16).
module tb_uart_tx_sequencer;

  localparam int DEPTH = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             push;
  logic [7:0]       push_data;
  logic             clr_ovf;
  logic             busy;
  logic             full;
  logic             overflow;
  logic [LVL_W-1:0] level;
  logic [31:0]      status;

  int checks = 0;
  int errors = 0;

  uart_tx_sequencer_if tx_bus ();

  uart_tx_sequencer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .clr_ovf   (clr_ovf),
    .tx        (tx_bus),
    .busy      (busy),
    .full      (full),
    .overflow  (overflow),
    .level     (level),
    .status    (status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic p, input logic [7:0] d,
                               input logic c, input logic r);
    push            = p;
    push_data       = d;
    clr_ovf         = c;
    tx_bus.tx_ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int idx;
    int n;
    logic prev_valid;
    logic prev_ready;
    logic r;
    logic [39:0] pat;
    logic [7:0]  exp3 [3];
    logic [7:0]  got [4];
    logic [7:0]  exp6 [4];
    int          exp6_n;

    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    step();
    rst = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst_valid", 32'(tx_bus.tx_valid), 32'd0);
    checkOutput("rst_data", 32'(tx_bus.tx_data), 32'h00);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_status", status, 32'h0);

    $display("[TB] single byte");
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t1_valid0", 32'(tx_bus.tx_valid), 32'd0);
    checkOutput("t1_level1", 32'(level), 32'd1);
    checkOutput("t1_busy1", 32'(busy), 32'd1);
    step();
    checkOutput("t1_valid1", 32'(tx_bus.tx_valid), 32'd1);
    checkOutput("t1_data", 32'(tx_bus.tx_data), 32'h41);
    checkOutput("t1_level0", 32'(level), 32'd0);
    step();
    checkOutput("t1_valid_drop", 32'(tx_bus.tx_valid), 32'd0);
    checkOutput("t1_busy0", 32'(busy), 32'd0);

    // One byte moves into the output register, so 18 pushes are needed to fill and drop one.
    $display("[TB] fill and overflow");
    for (int k = 0; k < 18; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t2_full", 32'(full), 32'd1);
    checkOutput("t2_level", 32'(level), 32'd16);
    checkOutput("t2_ovf", 32'(overflow), 32'd1);
    checkOutput("t2_head", 32'(tx_bus.tx_data), 32'h00);
    checkOutput("t2_status", status, 32'h0000_0610);
    tx_bus.tx_ready = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (tx_bus.tx_valid) begin
        checkOutput("t2_order", 32'(tx_bus.tx_data), 32'(idx));
        idx++;
      end
      step();
    end
    checkOutput("t2_count", 32'(idx), 32'd17);
    checkOutput("t2_empty_lvl", 32'(level), 32'd0);
    checkOutput("t2_ovf_sticky", 32'(overflow), 32'd1);

    $display("[TB] overflow clear");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    checkOutput("t5_clr", 32'(overflow), 32'd0);
    for (int k = 0; k < 17; k++) begin
      applyStimulus(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t5_full", 32'(full), 32'd1);
    checkOutput("t5_ovf_clear", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t5_set_wins", 32'(overflow), 32'd1);
    checkOutput("t5_level", 32'(level), 32'd16);

    $display("[TB] reset mid-transfer");
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("t4_valid", 32'(tx_bus.tx_valid), 32'd0);
    checkOutput("t4_data", 32'(tx_bus.tx_data), 32'h00);
    checkOutput("t4_level", 32'(level), 32'd0);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    checkOutput("t4_ovf", 32'(overflow), 32'd0);
    checkOutput("t4_full", 32'(full), 32'd0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    checkOutput("t4_post_valid", 32'(tx_bus.tx_valid), 32'd1);
    checkOutput("t4_post_data", 32'(tx_bus.tx_data), 32'h55);
    step();
    checkOutput("t4_post_drop", 32'(tx_bus.tx_valid), 32'd0);

    $display("[TB] push with pop, stalled handshake");
    applyStimulus(1'b1, 8'h61, 1'b0, 1'b0);
    step();
    checkOutput("t3_lvl_a", 32'(level), 32'd1);
    applyStimulus(1'b1, 8'h62, 1'b0, 1'b0);
    step();
    checkOutput("t3_lvl_pushpop", 32'(level), 32'd1);
    checkOutput("t3_first", 32'(tx_bus.tx_data), 32'h61);
    applyStimulus(1'b1, 8'h63, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t3_lvl_b", 32'(level), 32'd2);
    exp3[0] = 8'h61;
    exp3[1] = 8'h62;
    exp3[2] = 8'h63;
    pat = 40'b0010_0110_0001_0100_1100_0010_1001_0001_1000_1010;
    idx = 0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      r = pat[i];
      if (prev_valid && !prev_ready)
        checkOutput("t3_hold_valid", 32'(tx_bus.tx_valid), 32'd1);
      if (tx_bus.tx_valid) begin
        if (idx < 3) checkOutput("t3_data", 32'(tx_bus.tx_data), 32'(exp3[idx]));
        else checkOutput("t3_extra", 32'(idx), 32'd2);
      end
      tx_bus.tx_ready = r;
      prev_valid = tx_bus.tx_valid;
      prev_ready = r;
      if (tx_bus.tx_valid && r) idx++;
      step();
    end
    checkOutput("t3_count", 32'(idx), 32'd3);

    $display("[TB] LF handling");
`ifdef UART_TX_CRLF_EN
    exp6[0] = 8'h48; exp6[1] = 8'h0D; exp6[2] = 8'h0A; exp6[3] = 8'h69;
    exp6_n = 4;
`else
    exp6[0] = 8'h48; exp6[1] = 8'h0A; exp6[2] = 8'h69; exp6[3] = 8'h00;
    exp6_n = 3;
`endif
    n = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (tx_bus.tx_valid) begin
        if (n < 4) got[n] = tx_bus.tx_data;
        n++;
      end
      case (cyc)
        0: applyStimulus(1'b1, 8'h48, 1'b0, 1'b1);
        1: applyStimulus(1'b1, 8'h0A, 1'b0, 1'b1);
        2: applyStimulus(1'b1, 8'h69, 1'b0, 1'b1);
        default: applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      endcase
      step();
    end
    checkOutput("t6_count", 32'(n), 32'(exp6_n));
    for (int i = 0; i < 4; i++) begin
      if (i < exp6_n && i < n) checkOutput("t6_byte", 32'(got[i]), 32'(exp6[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
